tt_serial_sum_collector: RTL and testbench
==========================================

// Module: tt_serial_sum_collector
// PURPOSE
//   Stage directly downstream of the half-adder cell. Consumes one
//   (sum, carry) half-adder result per accepted beat (operands streamed
//   LSB first). Adds the registered ripple carry to form a full add,
//   deserialises WIDTH sum bits into a word, and presents the word with
//   an overflow flag on a valid/ready output port.
// PARAMETERS
//   WIDTH  4  result word width in bits; legal range 2..8
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      reset, synchronous, active-high
//   bit_valid  in   1      upstream half-adder beat valid
//   bit_ready  out  1      collector accepts beat this cycle
//   ha_s       in   1      half-adder sum   (x ^ y) of current bit
//   ha_c       in   1      half-adder carry (x & y) of current bit
//   bit_first  in   1      beat is bit 0 (LSB) of a new word
//   res_valid  out  1      res_data/res_ovf hold a completed word
//   res_ready  in   1      downstream consumes word this cycle
//   res_data   out  WIDTH  assembled sum, bit 0 = first beat
//   res_ovf    out  1      carry out of the MSB
//   busy       out  1      word in progress (SHIFT state)
// BEHAVIOUR
//   Clock is clk; reset is rst: synchronous, active-high.
//   Beat accepted when bit_valid && bit_ready.
//   Full add per accepted beat, using cy (carry register):
//     s = ha_s ^ cy_in; cy_next = ha_c | (ha_s & cy_in);
//     cy_in = 0 when bit_first=1, else cy.
//   Shift: sreg <= {s, sreg[WIDTH-1:1]}; word is LSB-aligned after WIDTH beats.
//   States:
//     IDLE : bit_ready=1. Accepted beat with bit_first=1 -> SHIFT, cnt=1.
//            A beat with bit_first=0 is accepted and discarded (stray bits).
//     SHIFT: bit_ready=1, busy=1. Each accepted beat increments cnt.
//            Beat with bit_first=1 aborts the partial word and restarts it:
//            cnt=1, cy_in=0. When the beat taken at cnt=WIDTH-1 is
//            accepted -> DONE; res_data<=final sreg, res_ovf<=cy_next.
//     DONE : res_valid=1; res_data/res_ovf held stable until handshake.
//            bit_ready = res_ready (zero-bubble chaining).
//            res_ready=1 and no beat -> IDLE.
//            res_ready=1 with accepted first beat -> SHIFT (new word, cnt=1).
//            res_ready=1 with accepted non-first beat -> discarded, IDLE.
//            res_ready=0 -> stay; upstream stalled.
//   Latency: res_valid rises the cycle after the WIDTH-th beat is accepted.
//   Throughput: one word per WIDTH cycles when res_ready is held high.
//   Reset values: state=IDLE, cnt=0, cy=0, sreg=0, res_data=0,
//     res_ovf=0, res_valid=0, busy=0, bit_ready=0 during reset.
//   Reset mid-word or in DONE drops the partial/pending word; no output.
//   Idle cycles (bit_valid=0) inside SHIFT freeze cnt, cy and sreg.
//   cnt width is $clog2(WIDTH+1); cnt never wraps past WIDTH-1.
//   ha_s=ha_c=1 is an illegal half-adder output. The add equations
//     above are applied anyway; the block does not check for it.
// TESTING
//   T1 WIDTH=4, 5+3: (ha_s,ha_c) = (0,1),(1,0),(1,0),(0,0), first on beat 0
//      -> res_data=4'b1000 (8), res_ovf=0, res_valid one cycle after beat 3.
//   T2 15+1: beats (0,1),(1,0),(1,0),(1,0) -> res_data=0, res_ovf=1.
//   T3 back-pressure: hold res_ready=0 for 5 cycles after T1
//      -> res_data stable at 8, bit_ready=0; release -> next word starts same cycle.
//   T4 abort: 2 beats of a word, then bit_first=1 starting 5+3
//      -> single result 8; no result for the aborted word.
//   T5 stray/gaps: 3 beats with bit_first=0 in IDLE, then T1 with bit_valid
//      toggling every other cycle -> strays ignored, result 8.
//   T6 rst=1 for 1 cycle after beat 2 of T2 -> no res_valid;
//      following T1 gives 8.

Source files
------------

// File: rtl/tt_serial_sum_collector.sv
// Serial full-add collector: completes a half-adder bit stream (LSB first) with a
// ripple carry, packs WIDTH sum bits into a word and hands it off on valid/ready.
module tt_serial_sum_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             ha_s,
    input  logic             ha_c,
    input  logic             bit_first,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;

    logic             accept_s;
    logic             cy_in_s;
    logic             s_bit_s;
    logic             cy_next_s;
    logic [WIDTH-1:0] shifted_s;

    // In DONE the upstream is only let through when the held word leaves this cycle.
    assign bit_ready = !rst && ((state_q == DONE) ? res_ready : 1'b1);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;

    // Full-add datapath, word framing and next-state selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cy_d       = cy_q;
        sreg_d     = sreg_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;

        accept_s  = bit_valid && bit_ready;
        cy_in_s   = bit_first ? 1'b0 : cy_q;
        s_bit_s   = ha_s ^ cy_in_s;
        cy_next_s = ha_c | (ha_s & cy_in_s);
        shifted_s = {s_bit_s, sreg_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (accept_s && bit_first) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_ONE;
                    cy_d    = cy_next_s;
                    sreg_d  = shifted_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (accept_s) begin
                    cy_d   = cy_next_s;
                    sreg_d = shifted_s;
                    if (bit_first) begin
                        cnt_d = CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = DONE;
                        cnt_d      = CNT_ZERO;
                        res_data_d = shifted_s;
                        res_ovf_d  = cy_next_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (res_ready) begin
                    if (accept_s && bit_first) begin
                        state_d = SHIFT;
                        cnt_d   = CNT_ONE;
                        cy_d    = cy_next_s;
                        sreg_d  = shifted_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            cy_q       <= 1'b0;
            sreg_q     <= '0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cy_q       <= cy_d;
            sreg_q     <= sreg_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_tt_serial_sum_collector.sv
// Scoreboard bench: arithmetic reference model of the serial add, driver pushes
// expected words, negedge monitor pops and checks on every output handshake.
module tb_tt_serial_sum_collector;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_valid = 1'b0;
    logic         bit_ready;
    logic         ha_s = 1'b0;
    logic         ha_c = 1'b0;
    logic         bit_first = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_ovf;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    logic [W:0] exp_q[$];
    int         word_s[$];
    int         word_c[$];
    bit         in_word = 1'b0;
    int         lat_req = 0;
    int         lat_seen = 0;
    bit         rr_force = 1'b1;
    bit         rr_val = 1'b1;

    tt_serial_sum_collector #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .ha_s(ha_s), .ha_c(ha_c), .bit_first(bit_first), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each beat carries x_i + y_i = s + 2c at weight 2^i.
    task automatic model_accept(input bit s, input bit c, input bit first);
        int total;
        logic [W:0] exp_word;
        if (first) begin
            word_s.delete();
            word_c.delete();
            in_word = 1'b1;
        end else if (!in_word) begin
            return;
        end
        word_s.push_back(s);
        word_c.push_back(c);
        if (word_s.size() == W) begin
            total = 0;
            for (int i = 0; i < W; i++) total += (word_s[i] + 2 * word_c[i]) << i;
            exp_word = total[W:0];
            exp_q.push_back(exp_word);
            in_word = 1'b0;
            lat_req++;
        end
    endtask

    task automatic send_beat(input bit s, input bit c, input bit first, input bit gap,
                             output int tries);
        bit acc;
        if (gap) begin
            bit_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b1;
        ha_s = s;
        ha_c = c;
        bit_first = first;
        tries = 0;
        forever begin
            @(negedge clk);
            acc = bit_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_accept(s, c, first);
                break;
            end
            tries++;
            if (tries > 300) begin
                check("beat_accept_timeout", 0, 1);
                break;
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] s_bits, input logic [W-1:0] c_bits,
                             input int nbeats, input bit gaps);
        int t;
        for (int i = 0; i < nbeats; i++)
            send_beat(s_bits[i], c_bits[i], (i == 0), gaps, t);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bit_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("bit_ready_in_reset", int'(bit_ready), 0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        in_word = 1'b0;
        word_s.delete();
        word_c.delete();
    endtask

    // Output-side ready: forced for directed cases, mostly-high random otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            res_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency, busy tracking, hold-stability and scoreboard pops.
    initial begin
        bit         hold_v = 1'b0;
        logic [W:0] hold_w = '0;
        logic [W:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                check("busy", int'(busy), int'(in_word));
                if (lat_seen != lat_req) begin
                    check("res_valid_latency", int'(res_valid), 1);
                    lat_seen = lat_req;
                end
                if (hold_v) begin
                    check("held_valid", int'(res_valid), 1);
                    check("held_word", int'({res_ovf, res_data}), int'(hold_w));
                end
                if (res_valid) begin
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_word", int'({res_ovf, res_data}), -1);
                        end else begin
                            exp_w = exp_q.pop_front();
                            check("res_data", int'(res_data), int'(exp_w[W-1:0]));
                            check("res_ovf", int'(res_ovf), int'(exp_w[W]));
                        end
                        hold_v = 1'b0;
                    end else begin
                        check("bit_ready_stalled", int'(bit_ready), 0);
                        hold_v = 1'b1;
                        hold_w = {res_ovf, res_data};
                    end
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        int t;
        int waited;
        do_reset(2);
        @(negedge clk);
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_res_data", int'(res_data), 0);
        check("reset_res_ovf", int'(res_ovf), 0);
        check("ready_after_reset", int'(bit_ready), 1);
        @(posedge clk);
        #1;

        // T1: 5+3 and T2: 15+1.
        send_word(4'b0110, 4'b0001, W, 1'b0);
        send_word(4'b1110, 4'b0001, W, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // T3: back-pressure for 5 cycles, then release with the next word queued.
        rr_val = 1'b0;
        send_word(4'b0110, 4'b0001, W, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rr_val = 1'b1;
        send_beat(1'b0, 1'b1, 1'b1, 1'b0, t);
        check("t3_chain_same_cycle", t, 0);
        send_beat(1'b1, 1'b0, 1'b0, 1'b0, t);
        send_beat(1'b1, 1'b0, 1'b0, 1'b0, t);
        send_beat(1'b1, 1'b0, 1'b0, 1'b0, t);
        repeat (3) @(posedge clk);
        #1;

        // T4: aborted partial word followed by 5+3.
        send_word(4'b0011, 4'b0000, 2, 1'b0);
        send_word(4'b0110, 4'b0001, W, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // T5: stray beats in IDLE, then 5+3 with bit_valid toggling.
        for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b0, 1'b0, 1'b0, t);
        send_word(4'b0110, 4'b0001, W, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // T6: reset after two beats of 15+1, then 5+3.
        send_word(4'b1110, 4'b0001, 2, 1'b0);
        do_reset(1);
        send_word(4'b0110, 4'b0001, W, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Randomised traffic with random back-pressure, gaps, strays and aborts.
        rr_force = 1'b0;
        for (int w = 0; w < 60; w++) begin
            logic [W-1:0] sb;
            logic [W-1:0] cb;
            int len;
            for (int i = 0; i < W; i++) begin
                int p;
                p = $urandom_range(0, 2);
                sb[i] = (p == 1);
                cb[i] = (p == 2);
            end
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W - 1) : W;
            if ($urandom_range(0, 7) == 0) send_beat(1'($urandom), 1'b0, 1'b0, 1'b0, t);
            send_word(sb, cb, len, ($urandom_range(0, 3) == 0));
        end

        rr_force = 1'b1;
        rr_val = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
